// File: rtl/dot_seq_pkg.sv
// dot_seq_pkg: shared widths and FSM state encoding for the dot-product sequencer
package dot_seq_pkg;
  localparam int OP_W = 4;
  localparam int PROD_W = 8;
  typedef enum logic [2:0] {S_SETTLE, S_IDLE, S_ISSUE, S_DROP, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/dot_seq_fifo.sv
// dot_seq_fifo: operand-pair FIFO; a push is refused when full even if a pop happens in the same cycle
module dot_seq_fifo import dot_seq_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W = 2 * OP_W
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_push, w_pop;
  assign o_full = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_empty = r_wr == r_rd;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_data = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge Clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop) r_rd <= r_rd + (AW+1)'(1);
    end
endmodule

// File: rtl/dot_seq.sv
// dot_seq: feeds buffered operand pairs to the repeated-addition multiplier and sums LEN products.
// DOT_SEQ_SAT_EN: saturating accumulator plus ovf output; otherwise the accumulator wraps.
module dot_seq import dot_seq_pkg::*; #(
  parameter int LEN = 4,
  parameter int DEPTH = 4,
  parameter int ACC_W = 10,
  parameter int SETTLE = 20
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_nr1,
  output logic [OP_W-1:0]   mul_nr2,
  input  logic [PROD_W-1:0] mul_prod,
  input  logic              mul_ack,
  output logic [ACC_W-1:0]  sum,
  output logic              sum_valid,
  output logic              busy
`ifdef DOT_SEQ_SAT_EN
  , output logic            ovf
`endif
);
  localparam int CW = 4;
  localparam int SW = $clog2(SETTLE + 1) + 1;
  state_t r_state, w_next;
  logic [SW-1:0] r_settle;
  logic [CW-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [2*OP_W-1:0] w_head;
  logic w_pop, w_empty, w_full, w_last;
`ifdef DOT_SEQ_SAT_EN
  logic [ACC_W:0] w_add;
  logic r_sat;
  assign w_add = {1'b0, r_acc} + (ACC_W+1)'(mul_prod);
`endif
  dot_seq_fifo #(.DEPTH(DEPTH), .W(2 * OP_W)) u_fifo (
    .Clk(Clk),
    .Rst(Rst),
    .i_push(in_valid),
    .i_pop(w_pop),
    .i_data({in_a, in_b}),
    .o_data(w_head),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign in_ready = !w_full;
  assign busy = r_state != S_SETTLE && r_state != S_IDLE;
  assign w_last = r_cnt == CW'(LEN - 1);
  always_comb begin
    w_next = r_state;
    w_pop = 1'b0;
    case (r_state)
      S_SETTLE: w_next = r_settle == '0 ? S_IDLE : S_SETTLE;
      S_IDLE: begin
        w_pop = !w_empty;
        w_next = w_empty ? S_IDLE : S_ISSUE;
      end
      S_ISSUE: w_next = S_DROP;
      S_DROP: w_next = S_WAIT;
      S_WAIT: if (mul_ack) begin
        w_pop = !w_last && !w_empty;
        w_next = w_last ? S_DONE : w_empty ? S_IDLE : S_ISSUE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_SETTLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      r_state <= S_SETTLE;
      r_settle <= SW'(SETTLE);
      r_cnt <= '0;
      r_acc <= '0;
      mul_start <= 1'b0;
      mul_nr1 <= '0;
      mul_nr2 <= '0;
      sum <= '0;
      sum_valid <= 1'b0;
`ifdef DOT_SEQ_SAT_EN
      r_sat <= 1'b0;
      ovf <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      mul_start <= w_next == S_ISSUE;
      sum_valid <= r_state == S_DONE;
      if (r_state == S_SETTLE && r_settle != '0) r_settle <= r_settle - SW'(1);
      if (w_pop) {mul_nr1, mul_nr2} <= w_head;
      if (r_state == S_WAIT && mul_ack) begin
        r_cnt <= r_cnt + CW'(1);
`ifdef DOT_SEQ_SAT_EN
        r_acc <= w_add[ACC_W] ? '1 : w_add[ACC_W-1:0];
        r_sat <= r_sat | w_add[ACC_W];
`else
        r_acc <= r_acc + ACC_W'(mul_prod);
`endif
      end
      if (r_state == S_DONE) begin
        sum <= r_acc;
        r_acc <= '0;
        r_cnt <= '0;
`ifdef DOT_SEQ_SAT_EN
        ovf <= r_sat;
        r_sat <= 1'b0;
`endif
      end
    end
endmodule

// File: doc/dot_seq.md
Name: dot_seq

Overview:
- Upstream sequencer for the 4-bit repeated-addition multiplier (start/ack, nr1/nr2 → prod).
- Buffers operand pairs, issues them one at a time to the multiplier, and collects each prod on ack.
- Accumulates LEN products and emits the dot-product sum with a one-cycle valid pulse.

Parameters:
- LEN, 4, operand pairs per dot product (1..15).
- DEPTH, 4, operand FIFO entries (power of 2, ≥2).
- ACC_W, 10, accumulator/sum width; 10 bits holds 4×225 = 900.
- SETTLE, 20, cycles after reset before the first issue; must be ≥ max multiplier latency (15+3).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  FIFO not full; a pair is pushed when in_valid & in_ready at the edge.
- in_a  input  4  multiplier operand (drives nr1, the iteration count).
- in_b  input  4  multiplicand (drives nr2).
- mul_start  output  1  registered; high exactly one cycle per issue.
- mul_nr1  output  4  registered; held stable from issue until ack.
- mul_nr2  output  4  registered; held stable from issue until ack.
- mul_prod  input  8  multiplier result; valid while mul_ack=1.
- mul_ack  input  1  multiplier done flag; stays high until the next start is taken.
- sum  output  ACC_W  last completed dot product; held until the next completion.
- sum_valid  output  1  one-cycle pulse when sum updates.
- busy  output  1  high in any state other than SETTLE and IDLE.

Behaviour:
- Reset (async, Rst=1):
  - mul_start=0, mul_nr1=0, mul_nr2=0, sum=0, sum_valid=0, busy=0.
  - FIFO emptied; accumulator=0; pair count=0; settle counter=SETTLE; state=SETTLE.
  - The multiplier has no reset. Reset mid-operation therefore does not stop it; SETTLE guarantees the multiplier has returned to idle before the next issue.
- FSM states:
  - SETTLE: decrement the settle counter each cycle; at 0 → IDLE.
  - IDLE: if FIFO non-empty → ISSUE and pop the head into mul_nr1/mul_nr2.
  - ISSUE: mul_start=1 for this cycle only → DROP.
  - DROP: one cycle; the multiplier clears ack on the edge that takes start, and stale ack=1 must be ignored here → WAIT.
  - WAIT: when mul_ack=1, acc <= acc + mul_prod (zero-extended) and count <= count+1.
    - If count+1 == LEN → DONE.
    - Otherwise, if FIFO non-empty → ISSUE with the next pair popped in the same cycle.
    - Otherwise → IDLE.
  - DONE: sum <= acc (or the saturated value); sum_valid=1 for one cycle; acc <= 0; count <= 0 → IDLE.
- Per-pair overhead beyond the multiplier latency: ISSUE+DROP, plus one WAIT sample cycle.
- Pairs with a=0: the multiplier returns prod=0 with ack two cycles after start; the pair still counts toward LEN.
- FIFO:
  - in_ready = !full. When full, a push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full/empty are both performed.
  - Read/write pointers wrap modulo DEPTH.
  - Operand order is preserved.
- Default arithmetic: acc is ACC_W bits and wraps modulo 2^ACC_W.
- mul_start is never asserted outside ISSUE; at most one multiplication is outstanding at any time.

Optional Feature:
- Macro: DOT_SEQ_SAT_EN.
- Defined:
  - The accumulator saturates at 2^ACC_W−1.
  - Extra output port ovf (1 bit, reset 0) is set in DONE if any add in that dot product saturated, and cleared in the next DONE that does not.
- Undefined:
  - The accumulator wraps modulo 2^ACC_W.
  - No ovf port exists.

Decomposition:
- Package dot_seq_pkg holds:
  - the state enum (SETTLE, IDLE, ISSUE, DROP, WAIT, DONE);
  - operand width constant OP_W=4;
  - product width constant PROD_W=8.
- One sub-module: dot_seq_fifo, a synchronous FIFO of DEPTH×(2·OP_W) with full/empty flags, clocked by Clk and reset by Rst.

Test Plan:
- Nominal sum: LEN=4; push (7,10), (3,5), (0,9), (15,15) → one sum_valid pulse with sum=310; mul_start pulses exactly 4 times.
- Zero operand: push pair (0,9) → mul_start pulse, prod=0 accepted, count advances, no hang.
- Backpressure: DEPTH=4, hold in_valid=1 while the multiplier is busy on (15,15) → in_ready=0 after 4 queued pairs; no pair is lost or duplicated, and the final sum matches the reference model.
- Reset mid-multiply: assert Rst while WAIT is processing (15,1) → outputs return to reset values immediately; no mul_start within SETTLE cycles; then (2,3)×4 → sum=24.
- Saturation: ACC_W=8, four pairs of (15,15):
  - with DOT_SEQ_SAT_EN → sum=255, ovf=1;
  - without it → sum=132 (900 mod 256).
- Back-to-back sets: 8 pairs of (1,1) pushed continuously → two sum_valid pulses, each with sum=4; acc is cleared between the two.
